hist2d_engine: RTL and testbench
================================

# hist2d_engine

2D-histogram accumulator for I/Q readout samples. It bins incoming (I,Q) coordinate strobes into a BRAM of 16-bit counters. On request it streams every bin out in raster order, clearing each bin as it is read so the next run starts empty. It sits between the I/Q discriminator/binning front end and the host readout path.

## Interface
- `DEPTH`, 1024: counter memory entries; must be ≥ max `i_bin_num*q_bin_num` used.
- `clk100` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `data_in` in 1: one-cycle strobe; `i_bin_coord`/`q_bin_coord` valid this cycle.
- `i_bin_coord`, `q_bin_coord` in 8: bin coordinates of the sample.
- `i_bin_num`, `q_bin_num` in 8: bins per axis; static during a run, each ≥1.
- `num_data_pts` in 16: points accepted per run; 0 means unlimited.
- `start_data_out` in 1: one-cycle strobe; starts the stream-out.
- `data_out` out 1: bin output valid, one cycle per bin.
- `bin_val` out 16: count of the emitted bin.
- `i_bin_out`, `q_bin_out` out 8: coordinates of the emitted bin.
- `hist_full` out 1: accepted count has reached `num_data_pts`.
- `busy` out 1: clearing or streaming; `data_in` and `start_data_out` are ignored while high.

## Operation
- Address mapping: `i*q_bin_num + q`, 16-bit product. Raster order is I outer, Q inner.
- States: CLEAR → IDLE ⇄ STREAM.
- CLEAR:
  - Entered on reset.
  - Writes 0 to all `DEPTH` addresses, one per cycle, then goes to IDLE.
  - `busy`=1 throughout.
- IDLE accumulate: on `data_in` with `i<i_bin_num`, `q<q_bin_num` and not `hist_full`:
  - Performs a read-modify-write of +1 on the addressed counter.
  - Counter saturates at 0xFFFF.
  - Increments the 16-bit accepted count.
  - Out-of-range or post-full strobes are dropped and not counted.
- `hist_full` = (`num_data_pts`≠0) && (count ≥ `num_data_pts`).
- IDLE → STREAM on `start_data_out`:
  - Reads each bin in raster order and emits it on `data_out`/`bin_val`/coords.
  - Writes 0 back to each bin after reading it.
  - After the last bin: count and `hist_full` clear, return to IDLE.
- A `start_data_out` during STREAM or CLEAR is ignored.
- A `data_in` arriving on the same cycle as `start_data_out` in IDLE: the start wins and the sample is dropped.

## Timing
- Memory: simple dual-port (1 read, 1 write), 1-cycle registered read.
- When a read and a write hit the same address in the same cycle, the read returns the new data.
- Accumulate:
  - Strobe at cycle t → read issued t → write t+1.
  - Updated value is visible to a read issued at t+2.
  - Minimum `data_in` spacing is 2 cycles; a strobe arriving while an RMW is pending is dropped.
- Stream:
  - Start sampled at t → address 0 read at t+1 → first `data_out` at t+2.
  - One bin per cycle after that, N=`i_bin_num*q_bin_num` pulses back-to-back.
  - Zero write-back of a bin happens in the cycle its value is emitted.
  - `busy` falls the cycle after the last `data_out`.
- Reset values:
  - All outputs 0, except `busy`=1 (CLEAR).
  - Accepted count 0.
  - Reset mid-stream or mid-RMW aborts the operation and re-clears the memory.
  - CLEAR lasts `DEPTH` cycles after `reset` falls.

## Structure
- Shared package `hist2d_pkg`:
  - `COORD_W`=8, `VAL_W`=16, `ADDR_W`=16.
  - State enum.
  - Address-mapping function.
- Sub-modules:
  - `hist2d_dpram`: parameterised DEPTH×16 simple dual-port memory.
  - Top level: store RMW, stream sequencer and memory-port mux.

## Test plan
- Reset, wait out CLEAR. Set 10×10 bins, `num_data_pts`=5. Pulse `data_in` at (0,0),(1,1),(2,2),(3,3) with 6-cycle spacing, then start → 100 `data_out` pulses; `bin_val`=1 at (0,0),(1,1),(2,2),(3,3), 0 elsewhere; `hist_full`=0.
- Three strobes at (4,7) with 2-cycle spacing → that bin streams `bin_val`=3. This exercises RMW hazard spacing.
- Strobe at (10,2) and (2,10) with 10×10 bins → dropped; all bins 0; accepted count unchanged.
- `num_data_pts`=5 with 6 strobes at (1,1) → `hist_full`=1 after the 5th; stream gives `bin_val`=5; `hist_full`=0 after the stream ends.
- Stream twice back-to-back → second stream emits all zeros (read-clear verified).
- Assert `reset` mid-stream at bin 37 → `data_out` stops, `busy` stays high through CLEAR; a subsequent stream is all zeros.

Source files
------------

// File: rtl/hist2d_pkg.sv
// Shared types and helpers for the 2D I/Q histogram engine.
package hist2d_pkg;

  localparam int unsigned COORD_W = 8;
  localparam int unsigned VAL_W   = 16;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  // Raster address of bin (i, q): I outer, Q inner, 16-bit product.
  function automatic logic [ADDR_W-1:0] bin_addr(input logic [COORD_W-1:0] i,
                                                 input logic [COORD_W-1:0] q,
                                                 input logic [COORD_W-1:0] nq);
    return ADDR_W'(ADDR_W'(i) * ADDR_W'(nq)) + ADDR_W'(q);
  endfunction

endpackage

// File: rtl/hist2d_engine_if.sv
// Sample/control/readout bundle between the binning front end, host and the engine.
interface hist2d_engine_if;
  import hist2d_pkg::*;

  logic               data_in;
  logic [COORD_W-1:0] i_bin_coord;
  logic [COORD_W-1:0] q_bin_coord;
  logic [COORD_W-1:0] i_bin_num;
  logic [COORD_W-1:0] q_bin_num;
  logic [CNT_W-1:0]   num_data_pts;
  logic               start_data_out;
  logic               data_out;
  logic [VAL_W-1:0]   bin_val;
  logic [COORD_W-1:0] i_bin_out;
  logic [COORD_W-1:0] q_bin_out;
  logic               hist_full;
  logic               busy;

  modport master (
    output data_in, i_bin_coord, q_bin_coord, i_bin_num, q_bin_num,
           num_data_pts, start_data_out,
    input  data_out, bin_val, i_bin_out, q_bin_out, hist_full, busy
  );

  modport slave (
    input  data_in, i_bin_coord, q_bin_coord, i_bin_num, q_bin_num,
           num_data_pts, start_data_out,
    output data_out, bin_val, i_bin_out, q_bin_out, hist_full, busy
  );

endinterface

// File: rtl/hist2d_dpram.sv
// Simple dual-port counter memory: one write, one registered read, write-first on collision.
module hist2d_dpram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
  end

endmodule

// File: rtl/hist2d_engine.sv
// 2D histogram accumulator: bins I/Q strobes into saturating counters, streams and clears on request.
module hist2d_engine
  import hist2d_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic             clk100,
  input  logic             reset,
  hist2d_engine_if.slave   bus
);

  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e              state_q, state_d;
  logic [MEM_AW-1:0]   clr_addr_q, clr_addr_d;
  logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
  logic                hist_full_q, hist_full_d;
  logic                busy_q;
  logic                rmw_pend_q, rmw_pend_d;
  logic [MEM_AW-1:0]   rmw_addr_q, rmw_addr_d;
  logic [COORD_W-1:0]  iss_i_q, iss_i_d, iss_q_q, iss_q_d;
  logic                iss_done_q, iss_done_d;
  logic                s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
  logic [COORD_W-1:0]  s1_i_q, s1_i_d, s1_q_q, s1_q_d;
  logic [MEM_AW-1:0]   s1_addr_q, s1_addr_d;
  logic                data_out_q, data_out_d, out_last_q, out_last_d;
  logic [VAL_W-1:0]    bin_val_q, bin_val_d;
  logic [COORD_W-1:0]  i_out_q, i_out_d, q_out_q, q_out_d;
  logic [MEM_AW-1:0]   wb_addr_q, wb_addr_d;

  logic                mem_we;
  logic [MEM_AW-1:0]   mem_waddr, mem_raddr;
  logic [VAL_W-1:0]    mem_wdata, mem_rdata;

  logic                full_now, start_ok, accept, stream_end, iss_last, iss_q_wrap;
  logic [ADDR_W-1:0]   strobe_addr, iss_addr;

  hist2d_dpram #(.DEPTH(DEPTH), .AW(MEM_AW), .DW(VAL_W)) u_mem (
    .clk     (clk100),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  assign strobe_addr = bin_addr(bus.i_bin_coord, bus.q_bin_coord, bus.q_bin_num);
  assign iss_addr    = bin_addr(iss_i_q, iss_q_q, bus.q_bin_num);
  assign full_now    = (bus.num_data_pts != '0) && (acc_cnt_q >= bus.num_data_pts);
  assign start_ok    = (state_q == ST_IDLE) && bus.start_data_out;
  // Start wins over a same-cycle sample; a strobe during a pending RMW is dropped.
  assign accept      = (state_q == ST_IDLE) && bus.data_in && !bus.start_data_out &&
                       !rmw_pend_q && !full_now &&
                       (bus.i_bin_coord < bus.i_bin_num) && (bus.q_bin_coord < bus.q_bin_num);
  assign stream_end  = (state_q == ST_STREAM) && data_out_q && out_last_q;
  assign iss_q_wrap  = (iss_q_q == bus.q_bin_num - COORD_W'(1));
  assign iss_last    = iss_q_wrap && (iss_i_q == bus.i_bin_num - COORD_W'(1));

  always_ff @(posedge clk100) begin
    if (reset) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR:  if (clr_addr_q == MEM_AW'(DEPTH - 1)) state_d = ST_IDLE;
      ST_IDLE:   if (start_ok)                         state_d = ST_STREAM;
      ST_STREAM: if (stream_end)                       state_d = ST_IDLE;
      default:                                         state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    clr_addr_d = clr_addr_q;
    acc_cnt_d  = acc_cnt_q;
    rmw_pend_d = accept;
    rmw_addr_d = rmw_addr_q;
    iss_i_d    = iss_i_q;
    iss_q_d    = iss_q_q;
    iss_done_d = iss_done_q;
    s1_vld_d   = 1'b0;
    s1_last_d  = s1_last_q;
    s1_i_d     = s1_i_q;
    s1_q_d     = s1_q_q;
    s1_addr_d  = s1_addr_q;
    data_out_d = s1_vld_q;
    out_last_d = out_last_q;
    bin_val_d  = bin_val_q;
    i_out_d    = i_out_q;
    q_out_d    = q_out_q;
    wb_addr_d  = wb_addr_q;
    mem_we     = 1'b0;
    mem_waddr  = clr_addr_q;
    mem_wdata  = '0;
    mem_raddr  = MEM_AW'(strobe_addr);

    unique case (state_q)
      ST_CLEAR: begin
        mem_we     = 1'b1;
        clr_addr_d = clr_addr_q + MEM_AW'(1);
      end
      ST_IDLE: begin
        if (accept) begin
          rmw_addr_d = MEM_AW'(strobe_addr);
          acc_cnt_d  = acc_cnt_q + CNT_W'(1);
        end
        if (start_ok) begin
          iss_i_d    = '0;
          iss_q_d    = '0;
          iss_done_d = 1'b0;
        end
      end
      ST_STREAM: begin
        if (!iss_done_q) begin
          mem_raddr  = MEM_AW'(iss_addr);
          s1_vld_d   = 1'b1;
          s1_i_d     = iss_i_q;
          s1_q_d     = iss_q_q;
          s1_last_d  = iss_last;
          s1_addr_d  = MEM_AW'(iss_addr);
          iss_done_d = iss_last;
          if (iss_q_wrap) begin
            iss_q_d = '0;
            iss_i_d = iss_i_q + COORD_W'(1);
          end else begin
            iss_q_d = iss_q_q + COORD_W'(1);
          end
        end
        if (stream_end) acc_cnt_d = '0;
      end
      default: ;
    endcase

    if (s1_vld_q) begin
      bin_val_d  = mem_rdata;
      i_out_d    = s1_i_q;
      q_out_d    = s1_q_q;
      out_last_d = s1_last_q;
      wb_addr_d  = s1_addr_q;
    end

    // Emitted bin is zeroed in its output cycle; otherwise finish a pending increment.
    if (state_q != ST_CLEAR) begin
      if (data_out_q) begin
        mem_we    = 1'b1;
        mem_waddr = wb_addr_q;
      end else if (rmw_pend_q) begin
        mem_we    = 1'b1;
        mem_waddr = rmw_addr_q;
        mem_wdata = (mem_rdata == '1) ? mem_rdata : mem_rdata + VAL_W'(1);
      end
    end

    hist_full_d = (bus.num_data_pts != '0) && (acc_cnt_d >= bus.num_data_pts);
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      clr_addr_q  <= '0;
      acc_cnt_q   <= '0;
      hist_full_q <= 1'b0;
      busy_q      <= 1'b1;
      rmw_pend_q  <= 1'b0;
      rmw_addr_q  <= '0;
      iss_i_q     <= '0;
      iss_q_q     <= '0;
      iss_done_q  <= 1'b1;
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_i_q      <= '0;
      s1_q_q      <= '0;
      s1_addr_q   <= '0;
      data_out_q  <= 1'b0;
      out_last_q  <= 1'b0;
      bin_val_q   <= '0;
      i_out_q     <= '0;
      q_out_q     <= '0;
      wb_addr_q   <= '0;
    end else begin
      clr_addr_q  <= clr_addr_d;
      acc_cnt_q   <= acc_cnt_d;
      hist_full_q <= hist_full_d;
      busy_q      <= (state_d != ST_IDLE);
      rmw_pend_q  <= rmw_pend_d;
      rmw_addr_q  <= rmw_addr_d;
      iss_i_q     <= iss_i_d;
      iss_q_q     <= iss_q_d;
      iss_done_q  <= iss_done_d;
      s1_vld_q    <= s1_vld_d;
      s1_last_q   <= s1_last_d;
      s1_i_q      <= s1_i_d;
      s1_q_q      <= s1_q_d;
      s1_addr_q   <= s1_addr_d;
      data_out_q  <= data_out_d;
      out_last_q  <= out_last_d;
      bin_val_q   <= bin_val_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      wb_addr_q   <= wb_addr_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.bin_val   = bin_val_q;
  assign bus.i_bin_out = i_out_q;
  assign bus.q_bin_out = q_out_q;
  assign bus.hist_full = hist_full_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_hist2d_engine.sv
// Directed bench for hist2d_engine on a 10x10 grid with a reference bin model.
module tb_hist2d_engine;
  import hist2d_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam int NI = 10;
  localparam int NQ = 10;
  localparam int NB = NI * NQ;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hist2d_engine_if bus_if();

  hist2d_engine #(.DEPTH(DEPTH)) dut (
    .clk100 (clk),
    .reset  (reset),
    .bus    (bus_if.slave)
  );

  int checks = 0;
  int errors = 0;
  int exp_bin [NB];
  int acc_model;
  int num_pts;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    foreach (exp_bin[b]) exp_bin[b] = 0;
    acc_model = 0;
  endtask

  task automatic set_num(input int n);
    num_pts = n;
    bus_if.num_data_pts = 16'(n);
  endtask

  // Counts edges after reset release until busy drops.
  task automatic wait_clear(input string tag);
    int n;
    int dout;
    n = 0;
    dout = 0;
    for (int k = 0; k < int'(DEPTH) + 20; k++) begin
      tick();
      n++;
      if (bus_if.data_out) dout++;
      if (!bus_if.busy) break;
    end
    chk({tag, " clear_len"}, n, int'(DEPTH));
    chk({tag, " clear_dout"}, dout, 0);
  endtask

  task automatic strobe(input int i, input int q, input int gap);
    bus_if.i_bin_coord = 8'(i);
    bus_if.q_bin_coord = 8'(q);
    bus_if.data_in = 1'b1;
    tick();
    bus_if.data_in = 1'b0;
    repeat (gap - 1) tick();
    if (i < NI && q < NQ && !(num_pts != 0 && acc_model >= num_pts)) begin
      exp_bin[i*NQ + q]++;
      acc_model++;
    end
  endtask

  task automatic run_stream(input string tag);
    int got_v [NB];
    int npulse, first_k, last_k, end_k, coord_err;
    npulse = 0; first_k = -1; last_k = -1; end_k = -1; coord_err = 0;
    foreach (got_v[b]) got_v[b] = -1;
    bus_if.start_data_out = 1'b1;
    tick();
    bus_if.start_data_out = 1'b0;
    for (int k = 1; k <= NB + 20; k++) begin
      @(negedge clk);
      if (bus_if.data_out) begin
        if (first_k < 0) first_k = k;
        last_k = k;
        if (npulse < NB) begin
          got_v[npulse] = int'(bus_if.bin_val);
          if (int'(bus_if.i_bin_out) != npulse / NQ || int'(bus_if.q_bin_out) != npulse % NQ)
            coord_err++;
        end
        npulse++;
      end else if (last_k > 0 && !bus_if.busy) begin
        end_k = k;
        break;
      end
    end
    chk({tag, " first_lat"}, first_k, 3);
    chk({tag, " pulses"}, npulse, NB);
    chk({tag, " contiguous"}, last_k - first_k + 1, NB);
    chk({tag, " busy_fall"}, end_k, NB + 3);
    chk({tag, " coords"}, coord_err, 0);
    for (int b = 0; b < NB; b++) chk($sformatf("%s bin%0d", tag, b), got_v[b], exp_bin[b]);
    chk({tag, " full_after"}, int'(bus_if.hist_full), 0);
    clear_model();
  endtask

  initial begin
    int hit;
    bus_if.data_in = 1'b0;
    bus_if.start_data_out = 1'b0;
    bus_if.i_bin_coord = '0;
    bus_if.q_bin_coord = '0;
    bus_if.i_bin_num = 8'(NI);
    bus_if.q_bin_num = 8'(NQ);
    set_num(5);
    clear_model();

    repeat (3) tick();
    chk("rst busy", int'(bus_if.busy), 1);
    chk("rst data_out", int'(bus_if.data_out), 0);
    chk("rst bin_val", int'(bus_if.bin_val), 0);
    chk("rst i_out", int'(bus_if.i_bin_out), 0);
    chk("rst q_out", int'(bus_if.q_bin_out), 0);
    chk("rst full", int'(bus_if.hist_full), 0);
    reset = 1'b0;
    wait_clear("boot");

    // Diagonal samples, below the point limit.
    for (int d = 0; d < 4; d++) strobe(d, d, 6);
    chk("diag full", int'(bus_if.hist_full), 0);
    run_stream("diag");

    // Back-to-back RMW on one bin.
    set_num(0);
    for (int n = 0; n < 3; n++) strobe(4, 7, 2);
    run_stream("rmw");

    // Out-of-range coordinates are not counted.
    set_num(1);
    strobe(10, 2, 2);
    strobe(2, 10, 2);
    chk("oor full", int'(bus_if.hist_full), 0);
    run_stream("oor");

    // Point limit reached on the fifth sample.
    set_num(5);
    for (int n = 0; n < 4; n++) strobe(1, 1, 2);
    chk("lim full4", int'(bus_if.hist_full), 0);
    strobe(1, 1, 2);
    chk("lim full5", int'(bus_if.hist_full), 1);
    strobe(1, 1, 2);
    chk("lim full6", int'(bus_if.hist_full), 1);
    run_stream("limit");

    // Corner bins, then a second stream reads back zeros.
    set_num(0);
    strobe(9, 9, 2);
    strobe(0, 9, 2);
    run_stream("b2b_1");
    run_stream("b2b_2");

    // Reset in the middle of a stream.
    strobe(5, 5, 2);
    strobe(4, 7, 2);
    hit = 0;
    bus_if.start_data_out = 1'b1;
    tick();
    bus_if.start_data_out = 1'b0;
    for (int k = 0; k < NB + 20; k++) begin
      @(negedge clk);
      if (bus_if.data_out && bus_if.i_bin_out == 8'd3 && bus_if.q_bin_out == 8'd7) begin
        hit = 1;
        break;
      end
    end
    chk("mid bin37_seen", hit, 1);
    reset = 1'b1;
    tick();
    chk("mid data_out", int'(bus_if.data_out), 0);
    chk("mid busy", int'(bus_if.busy), 1);
    tick();
    reset = 1'b0;
    wait_clear("mid");
    clear_model();
    run_stream("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
